// File: rtl/bound_flasher_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : bound_flasher_pkg
//  Purpose  : Shared types and default sizes for the bound-flasher step
//             scheduler and its flick debouncer.
//  Contents : sched_state_t  - 2-bit scheduler state encoding
//             CNT_W_DEF      - default width of the observed LED counter
//             DIV_W_DEF      - default width of the step divisor
//             DEB_LEN_DEF    - default debounce length (stable samples)
//  Revision : 1.0  initial release
// ============================================================================
package bound_flasher_pkg;

   localparam int CNT_W_DEF   = 5;
   localparam int DIV_W_DEF   = 16;
   localparam int DEB_LEN_DEF = 4;

   // IDLE  : waiting for a start request
   // RUN   : prescaler counting, step strobes issued at the terminal count
   // PAUSE : prescaler frozen, no strobes
   // DRAIN : final step seen, done pulse follows on the way back to IDLE
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DRAIN = 2'd3
   } sched_state_t;

endpackage : bound_flasher_pkg
`default_nettype wire

// File: rtl/flick_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : flick_debouncer
//  Purpose  : Brings the raw flick button into the clk domain with a 2-flop
//             synchroniser, then debounces it. The clean output only changes
//             after DEB_LEN consecutive synchronised samples that all differ
//             from the present output; any sample equal to the output
//             restarts the count. Raw-to-clean latency is 2+DEB_LEN cycles.
//  Ports    : clk          in  1  system clock, rising edge
//             rst          in  1  asynchronous reset, active-high
//             flick_raw    in  1  raw button level, asynchronous to clk
//             flick_clean  out 1  synchronised, debounced level
//  Params   : DEB_LEN      stable samples needed to change the output (>=2)
//  Revision : 1.0  initial release
// ============================================================================
module flick_debouncer
   import bound_flasher_pkg::*;
#(
   parameter int DEB_LEN = DEB_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic flick_raw,
   output logic flick_clean
);

   localparam int            CW   = $clog2(DEB_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_LEN - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] stable_cnt;

   // Two-stage synchroniser; sync_2 is the first flop safe to use as logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= flick_raw;
         sync_2 <= sync_1;
      end
   end

   // The count tracks how many samples in a row have disagreed with the
   // output. Reaching DEB_LEN flips the output and restarts from zero, so
   // the next change again needs a full run of disagreeing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_cnt  <= '0;
         flick_clean <= 1'b0;
      end else if (sync_2 == flick_clean) begin
         stable_cnt <= '0;
      end else if (stable_cnt == LAST) begin
         stable_cnt  <= '0;
         flick_clean <= sync_2;
      end else begin
         stable_cnt <= stable_cnt + ONE;
      end
   end

endmodule : flick_debouncer
`default_nettype wire

// File: rtl/flash_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : flash_step_scheduler
//  Purpose  : Paces and sequences the bound-flasher controller. Debounces the
//             flick button, runs a start/ack handshake, issues one-cycle
//             step_en strobes every div_q clocks while running, and detects
//             run completion from the controller's LED counter.
//  Ports    : clk          in  1      system clock, rising edge
//             rst          in  1      asynchronous reset, active-high
//             flick_raw    in  1      raw button level, asynchronous
//             start_req    in  1      run request, held until start_ack
//             start_ack    out 1      one-cycle acknowledge of start_req
//             pause        in  1      freezes pacing while high in RUN
//             divisor      in  DIV_W  clk cycles per step, sampled at ack
//             counter      in  CNT_W  LED counter from the controller
//             flick_clean  out 1      debounced flick to the controller
//             step_en      out 1      one-cycle advance strobe
//             busy         out 1      high while a run is in progress
//             done         out 1      one-cycle completion pulse
//  Params   : CNT_W, DIV_W, DEB_LEN
//  Revision : 1.0  initial release
// ============================================================================
module flash_step_scheduler
   import bound_flasher_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DIV_W   = DIV_W_DEF,
   parameter int DEB_LEN = DEB_LEN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flick_raw,
   input  logic             start_req,
   output logic             start_ack,
   input  logic             pause,
   input  logic [DIV_W-1:0] divisor,
   input  logic [CNT_W-1:0] counter,
   output logic             flick_clean,
   output logic             step_en,
   output logic             busy,
   output logic             done
);

   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   sched_state_t     state;
   sched_state_t     next_state;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] presc;
   logic             stepped;

   logic             at_terminal;
   logic             pacing;
   logic             ack_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   // ------------------------------------------------------------------------
   // Flick path: runs independently of the scheduler state.
   // ------------------------------------------------------------------------
   flick_debouncer #(
      .DEB_LEN (DEB_LEN)
   ) u_flick_debouncer (
      .clk         (clk),
      .rst         (rst),
      .flick_raw   (flick_raw),
      .flick_clean (flick_clean)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: begin
            if (start_req) begin
               next_state = S_RUN;
            end
         end
         S_RUN: begin
            // Pause wins: it also suppresses the strobe, so a pause on the
            // terminal count cannot coincide with a completing step.
            if (pause) begin
               next_state = S_PAUSE;
            end else if (step_en && stepped && (counter == '0)) begin
               next_state = S_DRAIN;
            end
         end
         S_PAUSE: begin
            if (!pause) begin
               next_state = S_RUN;
            end
         end
         S_DRAIN: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------------
   // The cycle in which start_ack is high is the first RUN cycle. It acts as
   // an arming cycle: the prescaler holds at 0, so the first strobe lands
   // exactly div_q cycles after the acknowledge.
   always_comb begin
      at_terminal = (presc == (div_q - DIV_ONE));
      pacing      = (state == S_RUN) && !start_ack && !pause;
      step_en     = pacing && at_terminal;
      ack_nxt     = (state == S_IDLE) && start_req;
      busy_nxt    = (next_state != S_IDLE);
      done_nxt    = (state == S_DRAIN);
   end

   // ------------------------------------------------------------------------
   // Registered outputs, divisor latch, prescaler and stepped flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_ack <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_q     <= DIV_ONE;
         presc     <= '0;
         stepped   <= 1'b0;
      end else begin
         start_ack <= ack_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         if (ack_nxt) begin
            // A zero divisor would never reach a terminal count; treat it
            // as the fastest rate instead.
            div_q   <= (divisor == '0) ? DIV_ONE : divisor;
            presc   <= '0;
            stepped <= 1'b0;
         end else if (pacing) begin
            if (at_terminal) begin
               presc   <= '0;
               stepped <= 1'b1;
            end else begin
               presc <= presc + DIV_ONE;
            end
         end
      end
   end

endmodule : flash_step_scheduler
`default_nettype wire

// File: tb/tb_flash_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flash_step_scheduler
//  Purpose  : Directed self-checking bench for flash_step_scheduler.
//             Cycle k below means the interval after the k-th rising edge
//             counted from the moment a scenario starts driving.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_flash_step_scheduler;

   logic        clk;
   logic        rst;
   logic        flick_raw;
   logic        start_req;
   logic        start_ack;
   logic        pause;
   logic [15:0] divisor;
   logic [4:0]  counter;
   logic        flick_clean;
   logic        step_en;
   logic        busy;
   logic        done;

   int n_cmp;
   int n_bad;

   flash_step_scheduler #(
      .CNT_W   (5),
      .DIV_W   (16),
      .DEB_LEN (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flick_raw   (flick_raw),
      .start_req   (start_req),
      .start_ack   (start_ack),
      .pause       (pause),
      .divisor     (divisor),
      .counter     (counter),
      .flick_clean (flick_clean),
      .step_en     (step_en),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Put the DUT into a known idle state; leaves time at edge+1.
   task automatic apply_reset();
      rst       = 1'b1;
      flick_raw = 1'b0;
      start_req = 1'b0;
      pause     = 1'b0;
      divisor   = 16'd4;
      counter   = 5'd5;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      rst       = 1'b1;
      flick_raw = 1'b0;
      start_req = 1'b0;
      pause     = 1'b0;
      divisor   = 16'd3;
      counter   = 5'd5;
      @(posedge clk);
      #1;
      obs = {start_ack, step_en, busy, done, flick_clean};
      n_cmp++;
      if (obs !== 5'b00000) begin
         n_bad++;
         $display("FAIL reset_state: got %b want 00000", obs);
      end
      rst = 1'b0;
      // start a divisor-3 run with the flick held high
      flick_raw = 1'b1;
      start_req = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(posedge clk);
         #1;
         if (j == 1) start_req = 1'b0;
         #1;
      end
      obs = {busy, flick_clean};
      n_cmp++;
      if (obs !== 2'b11) begin
         n_bad++;
         $display("FAIL pre_reset_run busy/clean: got %b want 11", obs);
      end
      // assert reset in the middle of cycle 8
      #1;
      rst       = 1'b1;
      flick_raw = 1'b0;
      #1;
      obs = {start_ack, step_en, busy, done, flick_clean};
      n_cmp++;
      if (obs !== 5'b00000) begin
         n_bad++;
         $display("FAIL mid_run_reset outputs: got %b want 00000", obs);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int j = 1; j <= 6; j++) begin
         @(posedge clk);
         #2;
         obs = {start_ack, step_en, busy, done, flick_clean};
         n_cmp++;
         if (obs !== 5'b00000) begin
            n_bad++;
            $display("FAIL post_reset_quiet cycle %0d: got %b want 00000", j, obs);
         end
      end
      // IDLE after reset: a request is acknowledged one cycle later
      start_req = 1'b1;
      @(posedge clk);
      #2;
      obs = {start_ack, busy, 3'b000};
      n_cmp++;
      if (obs !== 5'b11000) begin
         n_bad++;
         $display("FAIL post_reset_ack ack/busy: got %b want 11000", obs);
      end
      start_req = 1'b0;
   endtask

   // divisor=4: strobes on cycles 4, 8, 12 after the ack cycle (cycle 1)
   task automatic test_cadence();
      logic [3:0] obs;
      logic [3:0] exp;
      apply_reset();
      divisor   = 16'd4;
      counter   = 5'd5;
      start_req = 1'b1;
      for (int j = 1; j <= 13; j++) begin
         @(posedge clk);
         #1;
         if (j == 1) start_req = 1'b0;
         #1;
         obs = {start_ack, step_en, busy, done};
         exp = {(j == 1), (j == 5 || j == 9 || j == 13), 1'b1, 1'b0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL cadence_div4 cycle %0d ack/step/busy/done: got %b want %b", j, obs, exp);
         end
      end
   endtask

   // divisor=0 runs as div 1; changing divisor mid-run has no effect
   task automatic test_div_zero();
      logic [3:0] obs;
      logic [3:0] exp;
      apply_reset();
      divisor   = 16'd0;
      counter   = 5'd5;
      start_req = 1'b1;
      for (int j = 1; j <= 10; j++) begin
         @(posedge clk);
         #1;
         if (j == 1) start_req = 1'b0;
         if (j == 3) divisor = 16'd9;
         #1;
         obs = {start_ack, step_en, busy, done};
         exp = {(j == 1), (j >= 2), 1'b1, 1'b0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL div_zero cycle %0d ack/step/busy/done: got %b want %b", j, obs, exp);
         end
      end
   endtask

   // 2-cycle glitch is filtered; a 6-cycle press shows up 6 cycles later
   task automatic test_flick();
      logic exp;
      apply_reset();
      flick_raw = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         @(posedge clk);
         #1;
         if (j == 2) flick_raw = 1'b0;
         #1;
         n_cmp++;
         if (flick_clean !== 1'b0) begin
            n_bad++;
            $display("FAIL flick_glitch cycle %0d clean: got %b want 0", j, flick_clean);
         end
      end
      flick_raw = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk);
         #1;
         if (k == 6) flick_raw = 1'b0;
         #1;
         exp = (k >= 6) && (k < 12);
         n_cmp++;
         if (flick_clean !== exp) begin
            n_bad++;
            $display("FAIL flick_press cycle %0d clean: got %b want %b", k, flick_clean, exp);
         end
      end
   endtask

   // divisor=2, pause high for cycles 5..9 while the prescaler sits at 1
   task automatic test_pause();
      logic [3:0] obs;
      logic [3:0] exp;
      apply_reset();
      divisor   = 16'd2;
      counter   = 5'd5;
      start_req = 1'b1;
      for (int j = 1; j <= 15; j++) begin
         @(posedge clk);
         #1;
         if (j == 1)  start_req = 1'b0;
         if (j == 5)  pause = 1'b1;
         if (j == 10) pause = 1'b0;
         #1;
         obs = {start_ack, step_en, busy, done};
         exp = {(j == 1), (j == 3 || j == 11 || j == 13 || j == 15), 1'b1, 1'b0};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL pause cycle %0d ack/step/busy/done: got %b want %b", j, obs, exp);
         end
      end
   endtask

   // counter=0 on the first step is ignored; a later step with counter=0
   // drains, done pulses with busy low, and the held request re-acks.
   task automatic test_back_to_back();
      logic [3:0] obs;
      logic [3:0] exp;
      apply_reset();
      divisor   = 16'd2;
      counter   = 5'd0;
      start_req = 1'b1;
      for (int j = 1; j <= 11; j++) begin
         @(posedge clk);
         #1;
         if (j == 4) counter = 5'd7;
         if (j == 7) counter = 5'd0;
         #1;
         obs = {start_ack, step_en, busy, done};
         exp = {(j == 1 || j == 10),
                (j == 3 || j == 5 || j == 7),
                (j <= 8 || j >= 10),
                (j == 9)};
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL drain cycle %0d ack/step/busy/done: got %b want %b", j, obs, exp);
         end
      end
      start_req = 1'b0;
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      flick_raw = 1'b0;
      start_req = 1'b0;
      pause     = 1'b0;
      divisor   = 16'd0;
      counter   = 5'd0;
      test_reset();
      test_cadence();
      test_div_zero();
      test_flick();
      test_pause();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_flash_step_scheduler
`default_nettype wire
